ravens_pkt_arbiter: RTL and testbench

Sits between the DVS event decoder and the RAVENS packet input. It buffers spike packets in a small FIFO, generates periodic RUN packets from a cycle timer, and arbitrates those two sources plus host command packets onto one registered valid/ready packet output. Spike input is a strobe that cannot be back-pressured: overflow drops the packet and counts it.

---
 rtl/ravens_pkt_arbiter.sv | 132 +++++++++++++
 tb/tb_ravens_pkt_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ravens_pkt_arbiter.sv
// rtl/ravens_pkt_arbiter.sv - spike FIFO, RUN timer and fixed-priority packet arbiter
// Merges host commands, periodic RUN packets and buffered spikes onto one registered stream.
module ravens_pkt_arbiter #(
  parameter int         PKT_BITS   = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter int         RUN_PERIOD = 1000,
  parameter logic [2:0] RUN_OPCODE = 3'b011
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PKT_BITS-1:0]           spk_pkt,
  input  logic                          spk_valid,
  input  logic [PKT_BITS-1:0]           cmd_pkt,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          run_en,
  output logic [PKT_BITS-1:0]           out_pkt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic                          run_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RUN_PERIOD);
  localparam logic [PKT_BITS-1:0] RUN_PKT = {RUN_OPCODE, {(PKT_BITS-4){1'b0}}, 1'b1};

  logic [PKT_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PKT_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]       run_cnt_q, run_cnt_d;
  logic                run_pending_q, run_pending_d;
  logic                run_overrun_q, run_overrun_d;
  logic [PKT_BITS-1:0] out_pkt_q, out_pkt_d;
  logic                out_valid_q, out_valid_d;

  logic fifo_full, fifo_empty, load;
  logic sel_cmd, sel_run, sel_fifo, fifo_wr, run_wrap;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign load       = !out_valid_q || out_ready;
  assign sel_cmd    = load && cmd_valid;
  assign sel_run    = load && !cmd_valid && run_pending_q;
  assign sel_fifo   = load && !cmd_valid && !run_pending_q && !fifo_empty;
  // A full FIFO still takes a spike when the head leaves on the same edge.
  assign fifo_wr    = spk_valid && (!fifo_full || sel_fifo);
  assign run_wrap   = run_en && (run_cnt_q == CW'(RUN_PERIOD - 1));

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = spk_pkt;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (sel_fifo) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({fifo_wr, sel_fifo})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (spk_valid && !fifo_wr && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    run_cnt_d     = '0;
    run_pending_d = run_pending_q;
    run_overrun_d = run_overrun_q;
    if (run_en && !run_wrap) run_cnt_d = run_cnt_q + CW'(1);
    // Loading a RUN on a wrap edge hands the new period straight back to pending.
    if (sel_run) begin
      run_pending_d = run_wrap;
    end else if (run_wrap) begin
      run_pending_d = 1'b1;
      if (run_pending_q) run_overrun_d = 1'b1;
    end
  end

  always_comb begin
    out_pkt_d   = out_pkt_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = sel_cmd || sel_run || sel_fifo;
      if (sel_cmd)       out_pkt_d = cmd_pkt;
      else if (sel_run)  out_pkt_d = RUN_PKT;
      else if (sel_fifo) out_pkt_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      drop_cnt_q    <= '0;
      run_cnt_q     <= '0;
      run_pending_q <= 1'b0;
      run_overrun_q <= 1'b0;
      out_pkt_q     <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      drop_cnt_q    <= drop_cnt_d;
      run_cnt_q     <= run_cnt_d;
      run_pending_q <= run_pending_d;
      run_overrun_q <= run_overrun_d;
      out_pkt_q     <= out_pkt_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign cmd_ready   = sel_cmd;
  assign out_pkt     = out_pkt_q;
  assign out_valid   = out_valid_q;
  assign fifo_level  = level_q;
  assign drop_cnt    = drop_cnt_q;
  assign run_overrun = run_overrun_q;

endmodule

// File: tb/tb_ravens_pkt_arbiter.sv
// tb/tb_ravens_pkt_arbiter.sv - directed self-checking bench for ravens_pkt_arbiter
module tb_ravens_pkt_arbiter;

  localparam logic [31:0] RUN_PKT = 32'h6000_0001;
  localparam logic [31:0] CMD_PKT = 32'h8000_00C5;

  logic        clk;
  logic        rst_n;
  logic [31:0] spk_pkt;
  logic        spk_valid;
  logic [31:0] cmd_pkt;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        run_en;
  logic [31:0] out_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        run_overrun;

  int checks = 0;
  int errors = 0;
  int n;

  ravens_pkt_arbiter #(
    .PKT_BITS   (32),
    .FIFO_DEPTH (4),
    .RUN_PERIOD (10),
    .RUN_OPCODE (3'b011)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spk_pkt     (spk_pkt),
    .spk_valid   (spk_valid),
    .cmd_pkt     (cmd_pkt),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .run_en      (run_en),
    .out_pkt     (out_pkt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt),
    .run_overrun (run_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; spk_pkt = '0; spk_valid = 1'b0; cmd_pkt = '0; cmd_valid = 1'b0;
    run_en = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pkt", out_pkt, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_overrun", {31'd0, run_overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Spike path: two-cycle latency, single-cycle valid
    out_ready = 1'b1;
    spk_pkt = 32'h0000_0A20; spk_valid = 1'b1;
    tick();
    spk_valid = 1'b0;
    chk("spk_lat1_valid", {31'd0, out_valid}, 32'd0);
    chk("spk_lat1_level", {29'd0, fifo_level}, 32'd1);
    tick();
    chk("spk_valid", {31'd0, out_valid}, 32'd1);
    chk("spk_pkt", out_pkt, 32'h0000_0A20);
    chk("spk_level0", {29'd0, fifo_level}, 32'd0);
    tick();
    chk("spk_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("spk_hold_pkt", out_pkt, 32'h0000_0A20);

    // Overflow: 1 in output register, 4 buffered, 1 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spk_pkt = 32'h100 + i; spk_valid = 1'b1;
      tick();
    end
    spk_valid = 1'b0;
    chk("ovf_level", {29'd0, fifo_level}, 32'd4);
    chk("ovf_drop", {16'd0, drop_cnt}, 32'd1);
    chk("ovf_head", out_pkt, 32'h100);
    tick();
    chk("ovf_stall_pkt", out_pkt, 32'h100);
    chk("ovf_stall_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("ovf_order_pkt", out_pkt, 32'h100 + k);
      chk("ovf_order_valid", {31'd0, out_valid}, 32'd1);
    end
    tick();
    chk("ovf_drained", {31'd0, out_valid}, 32'd0);

    // Full FIFO with simultaneous write and pop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spk_pkt = 32'h200 + i; spk_valid = 1'b1;
      tick();
    end
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    spk_pkt = 32'h205; out_ready = 1'b1;
    tick();
    spk_valid = 1'b0;
    chk("wrpop_level", {29'd0, fifo_level}, 32'd4);
    chk("wrpop_drop", {16'd0, drop_cnt}, 32'd1);
    chk("wrpop_pkt", out_pkt, 32'h201);
    for (int k = 2; k < 6; k++) begin
      tick();
      chk("wrpop_order", out_pkt, 32'h200 + k);
    end
    tick();
    chk("wrpop_drained", {31'd0, out_valid}, 32'd0);

    // Priority: cmd, then RUN, then spike
    out_ready = 1'b0;
    spk_pkt = 32'h300; spk_valid = 1'b1;
    tick();
    spk_pkt = 32'h301;
    tick();
    spk_valid = 1'b0;
    chk("pri_held", out_pkt, 32'h300);
    chk("pri_level", {29'd0, fifo_level}, 32'd1);
    run_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    run_en = 1'b0;
    cmd_pkt = CMD_PKT; cmd_valid = 1'b1;
    #1;
    chk("pri_cmd_ready_stall", {31'd0, cmd_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("pri_cmd_ready_acc", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("pri_first_cmd", out_pkt, CMD_PKT);
    cmd_valid = 1'b0;
    #1;
    chk("pri_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("pri_second_run", out_pkt, RUN_PKT);
    tick();
    chk("pri_third_spk", out_pkt, 32'h301);
    chk("pri_third_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("pri_idle", {31'd0, out_valid}, 32'd0);
    chk("pri_no_overrun", {31'd0, run_overrun}, 32'd0);

    // RUN timing and overrun
    run_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 50);
    chk("run_first_lat", n, 32'd11);
    chk("run_first_pkt", out_pkt, RUN_PKT);
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 50);
    chk("run_gap", n, 32'd10);
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("run_overrun_set", {31'd0, run_overrun}, 32'd1);
    chk("run_stalled_pkt", out_pkt, RUN_PKT);
    run_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("run_pending_out", {31'd0, out_valid}, 32'd1);
    chk("run_pending_pkt", out_pkt, RUN_PKT);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("run_single_after", n, 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spk_pkt = 32'h400 + i; spk_valid = 1'b1;
      tick();
    end
    spk_valid = 1'b0;
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_level", {29'd0, fifo_level}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("async_rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("async_rst_overrun", {31'd0, run_overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
